adc_sample_sequencer: RTL and testbench
=======================================

# adc_sample_sequencer

Conversion sequencer and averaging stage that wraps the ADC capture path from both sides. It issues periodic single-cycle conversion requests on `init_signal` and accepts each returned byte on `done_pulse`/`data_out`, with a timeout guard. Accepted samples feed a 2^LOG2_N-deep moving average with hysteresis alarm, which is the filtered measurement the rest of the design consumes.

## Interface
- SAMPLE_DIV, 50000: clk cycles between conversion requests (≥ 4).
- TIMEOUT, 40000: clk cycles allowed in WAIT before abandoning a request (≥ 2).
- LOG2_N, 3: log2 of averaging window (1..6).
- TH_HIGH, 8'd200: alarm set threshold on average.
- TH_LOW, 8'd100: alarm clear threshold (TH_LOW < TH_HIGH).

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  asynchronous, active-high; clears all state.
- enable  in  1  level; runs the request timer.
- clear  in  1  one-cycle pulse; clears sticky flags.
- init_signal  out  1  one-cycle conversion request to the ADC capture block.
- done_pulse  in  1  one-cycle sample-valid strobe from the ADC capture block.
- data_out  in  8  ADC sample, valid while done_pulse = 1.
- avg_out  out  8  current window average.
- avg_valid  out  1  one-cycle strobe when avg_out is updated.
- alarm  out  1  hysteresis comparator on avg_out.
- sample_count  out  16  accepted samples, wraps 0xFFFF→0.
- timeout_err  out  1  sticky: a request timed out.
- overrun_err  out  1  sticky: a request slot was skipped because WAIT was still active.

## Operation
- Reset values: init_signal, avg_valid, alarm, timeout_err, overrun_err = 0; avg_out = 0; sample_count = 0; period counter, timeout counter, fill count, ring pointer and running sum = 0; all ring entries = 0; state = IDLE.
- Period counter: when enable = 1, counts 0..SAMPLE_DIV-1 and wraps. When enable = 0, it is held at 0. Terminal count (TC) occurs at value SAMPLE_DIV-1.
- States:
  - IDLE: on TC, drive init_signal = 1 on the next cycle and enter WAIT.
  - WAIT: the timeout counter increments each cycle.
    - On done_pulse, latch data_out and go to UPDATE.
    - When the timeout counter reaches TIMEOUT-1 without done_pulse, set timeout_err and return to IDLE.
    - done_pulse wins if it coincides with the timeout.
  - UPDATE: one cycle, then IDLE. Actions in this cycle:
    - sum ← sum − ring[ptr] + sample; ring[ptr] ← sample; ptr ← ptr+1 mod 2^LOG2_N.
    - fill count saturates at 2^LOG2_N; sample_count increments.
- TC while in WAIT or UPDATE: no request is issued and overrun_err is set.
- done_pulse outside WAIT is ignored and has no effect on any counter.
- Sum width is 8+LOG2_N bits and never overflows. avg_out = sum >> LOG2_N (truncation).
- avg_valid and avg_out update only when the fill count (after this update) equals 2^LOG2_N, so the first strobe comes on the 2^LOG2_N-th accepted sample.
- Alarm: evaluated only on avg_valid cycles using the new average. Set if avg ≥ TH_HIGH; cleared if avg ≤ TH_LOW; otherwise held.
- clear resets timeout_err and overrun_err. If clear coincides with a set event, the set wins.
- Deasserting enable while in WAIT does not abort the request: WAIT completes normally (by sample or timeout).

## Timing
- TC at cycle t → init_signal high at t+1 only → state = WAIT from t+1.
- done_pulse at cycle k (in WAIT) → UPDATE at k+1 → avg_out/avg_valid/alarm/sample_count visible at k+2.
- Timeout: the timeout counter is cleared on entering WAIT. A timeout occurring TIMEOUT cycles after the init_signal cycle makes timeout_err visible the following cycle.
- Reset asserted mid-WAIT or mid-UPDATE: immediate return to reset values, with no partial buffer write retained.
- Steady state: exactly one request per SAMPLE_DIV cycles while enable = 1 and no overrun occurs.

## Test plan
- Request cadence: SAMPLE_DIV=20, enable=1, ADC model answers 3 cycles after each request → init_signal pulses exactly 20 cycles apart, each 1 cycle wide; no error flags set.
- Fill and average: LOG2_N=2, samples 10, 20, 30, 40 → no avg_valid for the first three; avg_out=25 on the fourth. Next sample 200 → sum=290, avg_out=72.
- Hysteresis (TH_HIGH=200, TH_LOW=100):
  - 4×220 → alarm=1.
  - 4×150 → alarm stays 1.
  - 4×90 → alarm=0.
  - 4×150 → alarm stays 0.
- Timeout: TIMEOUT=10, no done_pulse → timeout_err=1 at 11 cycles after init_signal; sample_count unchanged. A late done_pulse is ignored. clear → flag 0.
- Overrun: TIMEOUT=30, SAMPLE_DIV=20, no response → second TC issues no init_signal and sets overrun_err=1. Clear and set in the same cycle → flag remains 1.
- Reset mid-operation: assert reset during WAIT after 3 samples → all outputs 0. After release, 4 new samples of 8 → first avg_valid with avg_out=8, unaffected by the earlier samples.

Source files
------------

// File: rtl/adc_sample_sequencer_if.sv
// Handshake between the sample sequencer and the ADC capture block.
// The sequencer side issues init_signal; the capture side returns done_pulse and data_out.
interface adc_sample_sequencer_if;
  logic       init_signal;
  logic       done_pulse;
  logic [7:0] data_out;

  modport master (output init_signal, input done_pulse, input data_out);
  modport slave  (input init_signal, output done_pulse, output data_out);
endinterface

// File: rtl/adc_sample_sequencer.sv
// Periodic ADC conversion sequencer with timeout guard, feeding a 2^LOG2_N moving
// average with a hysteresis alarm and sticky timeout/overrun flags.
module adc_sample_sequencer #(
  parameter int unsigned SAMPLE_DIV = 50000,
  parameter int unsigned TIMEOUT    = 40000,
  parameter int unsigned LOG2_N     = 3,
  parameter logic [7:0]  TH_HIGH    = 8'd200,
  parameter logic [7:0]  TH_LOW     = 8'd100
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  adc_sample_sequencer_if.master adc,
  output logic [7:0]             avg_out,
  output logic                   avg_valid,
  output logic                   alarm,
  output logic [15:0]            sample_count,
  output logic                   timeout_err,
  output logic                   overrun_err
);
  localparam int N  = 1 << LOG2_N;
  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int TW = $clog2(TIMEOUT);
  localparam int SW = 8 + LOG2_N;
  localparam int FW = LOG2_N + 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_UPDATE} state_t;

  state_t            state_q, state_d;
  logic [PW-1:0]     period_q, period_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic              init_q, init_d;
  logic [7:0]        sample_q, sample_d;
  logic [SW-1:0]     sum_q, sum_d;
  logic [LOG2_N-1:0] ptr_q, ptr_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [7:0]        ring_q [N];
  logic [7:0]        ring_d [N];
  logic [7:0]        avg_out_q, avg_out_d;
  logic              avg_valid_q, avg_valid_d;
  logic              alarm_q, alarm_d;
  logic [15:0]       count_q, count_d;
  logic              timeout_err_q, timeout_err_d;
  logic              overrun_err_q, overrun_err_d;

  logic              tc;
  logic              tmo_hit;
  logic [SW-1:0]     new_sum;
  logic [7:0]        new_avg;
  logic [FW-1:0]     fill_next;

  assign tc        = enable && (period_q == PW'(SAMPLE_DIV - 1));
  assign new_sum   = sum_q - SW'(ring_q[ptr_q]) + SW'(sample_q);
  assign new_avg   = new_sum[SW-1:LOG2_N];
  assign fill_next = (fill_q == FW'(N)) ? fill_q : fill_q + FW'(1);

  assign adc.init_signal = init_q;
  assign avg_out         = avg_out_q;
  assign avg_valid       = avg_valid_q;
  assign alarm           = alarm_q;
  assign sample_count    = count_q;
  assign timeout_err     = timeout_err_q;
  assign overrun_err     = overrun_err_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      period_q      <= '0;
      tmo_q         <= '0;
      init_q        <= 1'b0;
      sample_q      <= '0;
      sum_q         <= '0;
      ptr_q         <= '0;
      fill_q        <= '0;
      ring_q        <= '{default: '0};
      avg_out_q     <= '0;
      avg_valid_q   <= 1'b0;
      alarm_q       <= 1'b0;
      count_q       <= '0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      period_q      <= period_d;
      tmo_q         <= tmo_d;
      init_q        <= init_d;
      sample_q      <= sample_d;
      sum_q         <= sum_d;
      ptr_q         <= ptr_d;
      fill_q        <= fill_d;
      ring_q        <= ring_d;
      avg_out_q     <= avg_out_d;
      avg_valid_q   <= avg_valid_d;
      alarm_q       <= alarm_d;
      count_q       <= count_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    period_d    = '0;
    tmo_d       = '0;
    init_d      = 1'b0;
    sample_d    = sample_q;
    sum_d       = sum_q;
    ptr_d       = ptr_q;
    fill_d      = fill_q;
    ring_d      = ring_q;
    avg_out_d   = avg_out_q;
    avg_valid_d = 1'b0;
    alarm_d     = alarm_q;
    count_d     = count_q;
    tmo_hit     = 1'b0;

    if (enable && !tc) period_d = period_q + PW'(1);

    case (state_q)
      S_IDLE: begin
        if (tc) begin
          init_d  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // The request cycle itself leaves the counter at zero, so the guard
        // expires TIMEOUT cycles after init_signal.
        if (!init_q) tmo_d = tmo_q + TW'(1);
        if (adc.done_pulse) begin
          sample_d = adc.data_out;
          state_d  = S_UPDATE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_hit = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_UPDATE: begin
        sum_d         = new_sum;
        ring_d[ptr_q] = sample_q;
        ptr_d         = ptr_q + LOG2_N'(1);
        fill_d        = fill_next;
        count_d       = count_q + 16'd1;
        if (fill_next == FW'(N)) begin
          avg_out_d   = new_avg;
          avg_valid_d = 1'b1;
          if (new_avg >= TH_HIGH)     alarm_d = 1'b1;
          else if (new_avg <= TH_LOW) alarm_d = 1'b0;
        end
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    timeout_err_d = tmo_hit | (timeout_err_q & ~clear);
    overrun_err_d = (tc && state_q != S_IDLE) | (overrun_err_q & ~clear);
  end
endmodule

// File: tb/tb_adc_sample_sequencer.sv
// Bench for adc_sample_sequencer: an ADC responder plus a sliding-window reference
// model of the average, alarm and sample count.
module tb_adc_sample_sequencer;
  localparam int         SAMPLE_DIV = 20;
  localparam int         TIMEOUT    = 30;
  localparam int         LOG2_N     = 2;
  localparam int         N          = 4;
  localparam logic [7:0] TH_HIGH    = 8'd200;
  localparam logic [7:0] TH_LOW     = 8'd100;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        clear = 1'b0;
  logic [7:0]  avg_out;
  logic        avg_valid;
  logic        alarm;
  logic [15:0] sample_count;
  logic        timeout_err;
  logic        overrun_err;

  adc_sample_sequencer_if adc_bus();

  adc_sample_sequencer #(
    .SAMPLE_DIV(SAMPLE_DIV), .TIMEOUT(TIMEOUT), .LOG2_N(LOG2_N),
    .TH_HIGH(TH_HIGH), .TH_LOW(TH_LOW)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear), .adc(adc_bus),
    .avg_out(avg_out), .avg_valid(avg_valid), .alarm(alarm),
    .sample_count(sample_count), .timeout_err(timeout_err), .overrun_err(overrun_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int         checks = 0;
  int         errors = 0;
  int         window[$];
  int         exp_count;
  logic [7:0] exp_avg;
  bit         exp_alarm;
  int         last_init;
  bit         last_init_ok;

  function automatic void model_reset();
    window.delete();
    exp_count = 0;
    exp_avg   = 8'd0;
    exp_alarm = 1'b0;
  endfunction

  // Returns 1 when this sample completes a full window (an avg_valid strobe is due).
  function automatic bit model_push(input int v);
    int s;
    s = 0;
    window.push_back(v);
    if (window.size() > N) void'(window.pop_front());
    exp_count = (exp_count + 1) % 65536;
    if (window.size() != N) return 1'b0;
    foreach (window[i]) s += window[i];
    exp_avg = 8'(s / N);
    if (exp_avg >= TH_HIGH)     exp_alarm = 1'b1;
    else if (exp_avg <= TH_LOW) exp_alarm = 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_init(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (adc_bus.init_signal === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("[TB] FAIL init_wait: got no init_signal, required one within %0d cycles", budget);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    last_init_ok = 1'b0;
  endtask

  // Answers one request after dly cycles (dly >= 1) and checks the resulting outputs.
  task automatic do_request(input logic [7:0] v, input int dly);
    bit found;
    bit exp_valid;
    wait_init(SAMPLE_DIV + 5, found);
    if (!found) return;
    if (last_init_ok) begin
      checks++;
      if (cyc - last_init != SAMPLE_DIV) begin
        errors++;
        $display("[TB] FAIL cadence: got %0d cycles between requests, required %0d", cyc - last_init, SAMPLE_DIV);
      end
    end
    last_init    = cyc;
    last_init_ok = 1'b1;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (adc_bus.init_signal !== 1'b0) begin
          errors++;
          $display("[TB] FAIL init_width: got init_signal=%b one cycle later, required 0", adc_bus.init_signal);
        end
      end
    end
    adc_bus.done_pulse = 1'b1;
    adc_bus.data_out   = v;
    @(negedge clk);
    adc_bus.done_pulse = 1'b0;
    adc_bus.data_out   = 8'($urandom);
    checks++;
    if (avg_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL avg_valid_early: got %b during update cycle, required 0", avg_valid);
    end
    exp_valid = model_push(int'(v));
    @(negedge clk);
    checks++;
    if (avg_valid !== exp_valid) begin
      errors++;
      $display("[TB] FAIL avg_valid: got %b, required %b (sample %0d)", avg_valid, exp_valid, v);
    end
    checks++;
    if (avg_out !== exp_avg) begin
      errors++;
      $display("[TB] FAIL avg_out: got %0d, required %0d", avg_out, exp_avg);
    end
    checks++;
    if (alarm !== exp_alarm) begin
      errors++;
      $display("[TB] FAIL alarm: got %b, required %b (avg %0d)", alarm, exp_alarm, exp_avg);
    end
    checks++;
    if (sample_count !== 16'(exp_count)) begin
      errors++;
      $display("[TB] FAIL sample_count: got %0d, required %0d", sample_count, exp_count);
    end
    checks++;
    if (timeout_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL flags_clean: got timeout_err=%b overrun_err=%b, required 0 0", timeout_err, overrun_err);
    end
  endtask

  task automatic test_reset();
    bit seen;
    adc_bus.done_pulse = 1'b0;
    adc_bus.data_out   = 8'd0;
    apply_reset();
    @(negedge clk);
    checks++;
    if ({adc_bus.init_signal, avg_valid, alarm, timeout_err, overrun_err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_bits: got init/valid/alarm/tmo/ovr=%b, required 00000",
               {adc_bus.init_signal, avg_valid, alarm, timeout_err, overrun_err});
    end
    checks++;
    if (avg_out !== 8'd0 || sample_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_values: got avg_out=%0d sample_count=%0d, required 0 0", avg_out, sample_count);
    end
    seen = 1'b0;
    repeat (SAMPLE_DIV + 5) begin
      @(negedge clk);
      if (adc_bus.init_signal !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("[TB] FAIL disabled_idle: got init_signal with enable=0, required none");
    end
  endtask

  task automatic test_cadence();
    enable = 1'b1;
    for (int i = 0; i < 5; i++) do_request(8'($urandom), 3);
  endtask

  task automatic test_fill_average();
    apply_reset();
    do_request(8'd10, 2);
    do_request(8'd20, 3);
    do_request(8'd30, 1);
    do_request(8'd40, 4);
    checks++;
    if (avg_out !== 8'd25) begin
      errors++;
      $display("[TB] FAIL fill_avg: got %0d, required 25", avg_out);
    end
    do_request(8'd200, 2);
    checks++;
    if (avg_out !== 8'd72) begin
      errors++;
      $display("[TB] FAIL slide_avg: got %0d, required 72", avg_out);
    end
  endtask

  task automatic test_hysteresis();
    logic [7:0] level [4];
    bit         want  [4];
    level = '{8'd220, 8'd150, 8'd90, 8'd150};
    want  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int g = 0; g < 4; g++) begin
      for (int k = 0; k < 4; k++) do_request(level[g], 1 + (k % 3));
      checks++;
      if (alarm !== want[g]) begin
        errors++;
        $display("[TB] FAIL hysteresis_%0d: got alarm=%b after 4x%0d, required %b", g, alarm, level[g], want[g]);
      end
    end
  endtask

  task automatic test_timeout();
    bit found;
    wait_init(SAMPLE_DIV + 5, found);
    if (!found) return;
    enable       = 1'b0;
    last_init_ok = 1'b0;
    repeat (TIMEOUT) @(negedge clk);
    checks++;
    if (timeout_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_early: got %b at %0d cycles after request, required 0", timeout_err, TIMEOUT);
    end
    @(negedge clk);
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_set: got %b at %0d cycles after request, required 1", timeout_err, TIMEOUT + 1);
    end
    adc_bus.done_pulse = 1'b1;
    adc_bus.data_out   = 8'hFF;
    @(negedge clk);
    adc_bus.done_pulse = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (sample_count !== 16'(exp_count) || avg_out !== exp_avg) begin
      errors++;
      $display("[TB] FAIL late_done: got count=%0d avg=%0d, required %0d %0d", sample_count, avg_out, exp_count, exp_avg);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL timeout_clear: got tmo=%b ovr=%b, required 0 0", timeout_err, overrun_err);
    end
    enable = 1'b1;
  endtask

  task automatic test_overrun();
    bit found;
    bit saw_init;
    wait_init(SAMPLE_DIV + 5, found);
    if (!found) return;
    last_init_ok = 1'b0;
    repeat (SAMPLE_DIV - 1) @(negedge clk);
    checks++;
    if (overrun_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_early: got %b before second slot, required 0", overrun_err);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (overrun_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_set_wins: got %b, required 1", overrun_err);
    end
    saw_init = (adc_bus.init_signal !== 1'b0);
    repeat (TIMEOUT - SAMPLE_DIV + 1) begin
      @(negedge clk);
      if (adc_bus.init_signal !== 1'b0) saw_init = 1'b1;
    end
    checks++;
    if (saw_init) begin
      errors++;
      $display("[TB] FAIL overrun_no_request: got init_signal during WAIT, required none");
    end
    checks++;
    if (timeout_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_timeout: got timeout_err=%b, required 1", timeout_err);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    checks++;
    if (timeout_err !== 1'b0 || overrun_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_clear: got tmo=%b ovr=%b, required 0 0", timeout_err, overrun_err);
    end
    do_request(8'($urandom), 2);
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      do_request(8'($urandom), int'($urandom_range(1, 6)));
      adc_bus.done_pulse = 1'b1;
      adc_bus.data_out   = 8'($urandom);
      @(negedge clk);
      adc_bus.done_pulse = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    apply_reset();
    for (int i = 0; i < 3; i++) do_request(8'($urandom_range(100, 255)), 2);
    wait_init(SAMPLE_DIV + 5, found);
    if (!found) return;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({adc_bus.init_signal, avg_valid, alarm, timeout_err, overrun_err} !== 5'b0 ||
        avg_out !== 8'd0 || sample_count !== 16'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid: got bits=%b avg=%0d count=%0d, required all 0",
               {adc_bus.init_signal, avg_valid, alarm, timeout_err, overrun_err}, avg_out, sample_count);
    end
    reset = 1'b0;
    model_reset();
    last_init_ok = 1'b0;
    for (int i = 0; i < 4; i++) do_request(8'd8, 1 + i);
    checks++;
    if (avg_out !== 8'd8) begin
      errors++;
      $display("[TB] FAIL reset_mid_avg: got %0d, required 8", avg_out);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no completion by time limit, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_cadence();
    test_fill_average();
    test_hysteresis();
    test_timeout();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
